// File: rtl/ct_f_spsram_param.sv
// ---------------------------------------------------------------------------
// ct_f_spsram_param
//   Generic single-port SRAM model for FPGA/simulation builds of the cache
//   and TLB arrays. It can stand in for any fixed-geometry spsram wrapper.
//
//   Features:
//     - arbitrary width and depth (depth need not be a power of two)
//     - per-bit write mask
//     - read latency of 1 or 2 cycles
//     - output held between accesses
//     - hardware clear of the whole array after reset
//
//   Ports:
//     CLK        clock, all logic on the rising edge
//     cpurst_b   synchronous active-low reset
//     A          word address
//     CEN        chip enable, active-low
//     GWEN       global write enable, active-low (0 = write, 1 = read)
//     WEN        per-bit write enable, active-low
//     D          write data
//     Q          read data (write-through on writes, 0 for out-of-range)
//     INIT_DONE  array cleared and ready for access
// ---------------------------------------------------------------------------
module ct_f_spsram_param #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 88,
    parameter int DEPTH      = 2048,
    parameter int RD_LAT     = 1,
    parameter int INIT_EN    = 1
) (
    input  logic                  CLK,
    input  logic                  cpurst_b,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  INIT_DONE
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
            $error("ct_f_spsram_param: RD_LAT must be 1 or 2");
        end
        if ((DEPTH < 1) || (IDX_W > ADDR_WIDTH)) begin : g_bad_depth
            $error("ct_f_spsram_param: DEPTH must be 1..2**ADDR_WIDTH");
        end
    endgenerate

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        init_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    acc_p0;
    logic                    wr_p0;
    logic                    in_rng_p0;
    logic [IDX_W-1:0]        idx_p0;
    logic [DATA_WIDTH-1:0]   old_p0;
    logic [DATA_WIDTH-1:0]   wdat_p0;
    logic [DATA_WIDTH-1:0]   res_p0;
    logic [DATA_WIDTH-1:0]   data_p1;

    // ---- p0: access decode, array read and masked merge ----
    always_comb begin
        in_rng_p0 = (32'(A) < DEPTH);
        idx_p0    = A[IDX_W-1:0];
        acc_p0    = (state == ST_READY) && !CEN;
        wr_p0     = acc_p0 && !GWEN && in_rng_p0;
        old_p0    = in_rng_p0 ? mem[idx_p0] : '0;
        // WEN is active-low: a 1 keeps the stored bit, a 0 takes D.
        wdat_p0   = (old_p0 & WEN) | (D & ~WEN);
        if (!in_rng_p0) begin
            res_p0 = '0;
        end else if (!GWEN) begin
            res_p0 = wdat_p0;
        end else begin
            res_p0 = old_p0;
        end
    end

    // Array storage is never reset; the INIT sweep zeroes it instead.
    always_ff @(posedge CLK) begin
        if (cpurst_b) begin
            if (state == ST_INIT) begin
                mem[init_cnt] <= '0;
            end else if (wr_p0) begin
                mem[idx_p0] <= wdat_p0;
            end
        end
    end

    // Clear sequencer: one word per cycle, INIT_DONE follows the last write.
    always_ff @(posedge CLK) begin
        if (!cpurst_b) begin
            state     <= (INIT_EN != 0) ? ST_INIT : ST_READY;
            init_cnt  <= '0;
            INIT_DONE <= 1'b0;
        end else if (state == ST_INIT) begin
            if (init_cnt == IDX_W'(DEPTH - 1)) begin
                state     <= ST_READY;
                INIT_DONE <= 1'b1;
            end else begin
                init_cnt <= init_cnt + 1'b1;
            end
        end else begin
            INIT_DONE <= 1'b1;
        end
    end

    // ---- p1: first output register, loads only on an accepted access ----
    always_ff @(posedge CLK) begin
        if (!cpurst_b) begin
            data_p1 <= '0;
        end else if (acc_p0) begin
            data_p1 <= res_p0;
        end
    end

    // ---- p2: optional second output register ----
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic                  vld_p1;
            logic [DATA_WIDTH-1:0] data_p2;

            always_ff @(posedge CLK) begin
                if (!cpurst_b) begin
                    vld_p1  <= 1'b0;
                    data_p2 <= '0;
                end else begin
                    vld_p1 <= acc_p0;
                    if (vld_p1) begin
                        data_p2 <= data_p1;
                    end
                end
            end

            assign Q = data_p2;
        end else begin : g_lat1
            assign Q = data_p1;
        end
    endgenerate

endmodule

// File: tb/tb_ct_f_spsram_param.sv
module tb_ct_f_spsram_param;

    logic        CLK;
    logic        cpurst_b;
    logic [10:0] A;
    logic        CEN;
    logic        GWEN;
    logic [87:0] WEN;
    logic [87:0] D;
    logic [87:0] Q0;
    logic [87:0] Q1;
    logic        INIT_DONE0;
    logic        INIT_DONE1;

    // dut0: default geometry, 1-cycle latency
    ct_f_spsram_param #(
        .ADDR_WIDTH(11), .DATA_WIDTH(88), .DEPTH(2048), .RD_LAT(1), .INIT_EN(1)
    ) dut0 (
        .CLK(CLK), .cpurst_b(cpurst_b), .A(A), .CEN(CEN), .GWEN(GWEN),
        .WEN(WEN), .D(D), .Q(Q0), .INIT_DONE(INIT_DONE0)
    );

    // dut1: non-power-of-two depth, 2-cycle latency
    ct_f_spsram_param #(
        .ADDR_WIDTH(10), .DATA_WIDTH(88), .DEPTH(1000), .RD_LAT(2), .INIT_EN(1)
    ) dut1 (
        .CLK(CLK), .cpurst_b(cpurst_b), .A(A[9:0]), .CEN(CEN), .GWEN(GWEN),
        .WEN(WEN), .D(D), .Q(Q1), .INIT_DONE(INIT_DONE1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [87:0] d;
        int          due;
    } ent_t;

    ent_t        q0[$];
    ent_t        q1[$];
    logic [87:0] m0 [0:2047];
    logic [87:0] m1 [0:999];
    logic [87:0] e0 = '0;
    logic [87:0] e1 = '0;
    bit          rdy0 = 1'b0;
    bit          rdy1 = 1'b0;
    int          ecnt = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    localparam logic [87:0] PAT_A5   = {11{8'hA5}};
    localparam logic [87:0] PAT_X    = {11{8'h3C}};
    localparam logic [87:0] PAT_Y    = {11{8'hC3}};
    localparam logic [87:0] PAT_OOR  = {11{8'h5A}};
    localparam logic [87:0] MASK_EXP = {44'hFFF_FFFF_FFFF, 44'h0};

    task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Output monitor: pops results when they fall due, checks Q every cycle.
    always @(posedge CLK) begin
        logic rst_s;
        ent_t e;
        rst_s = cpurst_b;
        ecnt++;
        #1;
        if (!rst_s) begin
            q0.delete();
            q1.delete();
            e0 = '0;
            e1 = '0;
        end else begin
            while (q0.size() > 0 && q0[0].due == ecnt) begin
                e = q0.pop_front();
                e0 = e.d;
            end
            while (q1.size() > 0 && q1[0].due == ecnt) begin
                e = q1.pop_front();
                e1 = e.d;
            end
        end
        chk("q_dut0", Q0, e0);
        chk("q_dut1", Q1, e1);
    end

    task automatic acc(input logic cen_i, input logic gwen_i, input logic [10:0] a,
                       input logic [87:0] wen_i, input logic [87:0] d_i);
        ent_t       e;
        logic [9:0] a1;
        @(negedge CLK);
        CEN = cen_i; GWEN = gwen_i; A = a; WEN = wen_i; D = d_i;
        a1 = a[9:0];
        if (!cen_i && rdy0) begin
            if (!gwen_i) m0[a] = (m0[a] & wen_i) | (d_i & ~wen_i);
            e.d   = m0[a];
            e.due = ecnt + 1;
            q0.push_back(e);
        end
        if (!cen_i && rdy1) begin
            e.d = '0;
            if (int'(a1) < 1000) begin
                if (!gwen_i) m1[a1] = (m1[a1] & wen_i) | (d_i & ~wen_i);
                e.d = m1[a1];
            end
            e.due = ecnt + 2;
            q1.push_back(e);
        end
    endtask

    task automatic wr(input logic [10:0] a, input logic [87:0] d_i);
        acc(1'b0, 1'b0, a, '0, d_i);
    endtask

    task automatic rd(input logic [10:0] a);
        acc(1'b0, 1'b1, a, $urandom_range(0, 1) ? '1 : '0, {3{$urandom}});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            CEN = 1'b1;
            D   = {3{$urandom}};
        end
    endtask

    task automatic pulse_reset;
        @(negedge CLK);
        cpurst_b = 1'b0; CEN = 1'b1;
        rdy0 = 1'b0; rdy1 = 1'b0;
        @(negedge CLK);
        cpurst_b = 1'b1;
    endtask

    // Called right after reset release; measures how many edges until ready.
    task automatic wait_init(input bit inject);
        int t0;
        int t1;
        t0 = 0;
        t1 = 0;
        for (int i = 0; i < 2048; i++) m0[i] = '0;
        for (int i = 0; i < 1000; i++) m1[i] = '0;
        for (int n = 1; n <= 3000; n++) begin
            @(posedge CLK);
            #1;
            if (inject && n == 5) begin
                CEN = 1'b0; GWEN = 1'b0; A = 11'h010; WEN = '0; D = '1;
            end
            if (inject && n == 6) CEN = 1'b1;
            if (INIT_DONE0 && t0 == 0) t0 = n;
            if (INIT_DONE1 && t1 == 0) t1 = n;
            if (t0 != 0 && t1 != 0) break;
        end
        chk("init_cycles_dut0", 88'(t0), 88'(2048));
        chk("init_cycles_dut1", 88'(t1), 88'(1000));
        rdy0 = 1'b1;
        rdy1 = 1'b1;
    endtask

    initial begin
        cpurst_b = 1'b0; CEN = 1'b1; GWEN = 1'b1; A = '0; WEN = '1; D = '0;
        repeat (3) @(negedge CLK);
        chk("reset_init_done0", 88'(INIT_DONE0), 88'(0));
        chk("reset_init_done1", 88'(INIT_DONE1), 88'(0));
        cpurst_b = 1'b1;

        // Init sweep with a write attempt during INIT
        wait_init(1'b1);
        rd(11'h000); rd(11'h7FF); rd(11'h010);
        idle(3);

        // Masked write
        wr(11'h123, '1);
        acc(1'b0, 1'b0, 11'h123, {{44{1'b1}}, {44{1'b0}}}, '0);
        rd(11'h123);
        @(posedge CLK); #1;
        chk("mask_read_dut0", Q0, MASK_EXP);
        idle(2);

        // Latency and hold
        wr(11'h005, PAT_A5);
        rd(11'h000);
        rd(11'h005);
        idle(10);

        // Back-to-back pipelining
        wr(11'h002, PAT_Y);
        rd(11'h000);
        wr(11'h001, PAT_X);
        rd(11'h001);
        rd(11'h002);
        idle(4);

        // Out-of-range on the 1000-word instance
        wr(11'h3E8, PAT_OOR);
        rd(11'h3E8);
        rd(11'h000);
        idle(4);

        // Mid-init reset
        wr(11'd1500, 88'hFF);
        rd(11'd1500);
        idle(3);
        pulse_reset();
        repeat (700) @(posedge CLK);
        pulse_reset();
        wait_init(1'b0);
        rd(11'd1500);
        idle(4);

        chk("queues_drained", 88'(q0.size() + q1.size()), 88'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
